// File: rtl/ascii_case_stream.sv
// ascii_case_stream: multi-lane ASCII case converter with a valid/ready handshake,
// one registered output stage and a saturating count of case-changed bytes.
// Optional build macro ASCII_CASE_EXT_EN extends conversion to Latin-1 letters.
module ascii_case_stream #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   conv_cnt
);

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_UPPER  = 2'b01,
    MODE_LOWER  = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_e;

  // Sum is held wide enough for both CNT_W+1 and the largest per-beat count (16).
  localparam int SUM_W = (CNT_W + 1 > 5) ? CNT_W + 1 : 5;
  localparam logic [SUM_W-1:0] CNT_MAX = (SUM_W'(1) << CNT_W) - SUM_W'(1);

  logic               validQ, validD;
  logic [8*LANES-1:0] dataQ, dataD;
  logic [CNT_W-1:0]   cntQ, cntD;
  logic [8*LANES-1:0] convData;
  logic [LANES-1:0]   flipVec;
  logic [4:0]         changeCnt;
  logic               accept;
  logic [SUM_W-1:0]   cntBase;
  logic [SUM_W-1:0]   cntSum;

  // Decides whether bit 5 of one byte flips under the given mode.
  function automatic logic caseFlip(input logic [7:0] b, input logic [1:0] m);
    logic isUpper;
    logic isLower;
    logic flip;
    isUpper = (b >= 8'h41) && (b <= 8'h5A);
    isLower = (b >= 8'h61) && (b <= 8'h7A);
`ifdef ASCII_CASE_EXT_EN
    isUpper = isUpper | ((b >= 8'hC0) && (b <= 8'hDE) && (b != 8'hD7));
    isLower = isLower | ((b >= 8'hE0) && (b <= 8'hFE) && (b != 8'hF7));
`endif
    case (mode_e'(m))
      MODE_UPPER:  flip = isLower;
      MODE_LOWER:  flip = isUpper;
      MODE_TOGGLE: flip = isUpper | isLower;
      default:     flip = 1'b0;
    endcase
    return flip;
  endfunction

  assign in_ready  = ~validQ | out_ready;
  assign accept    = in_valid & in_ready;
  assign out_valid = validQ;
  assign out_data  = dataQ;
  assign conv_cnt  = cntQ;

  // Convert every lane independently and count how many bytes changed case.
  always_comb begin
    convData  = '0;
    flipVec   = '0;
    changeCnt = '0;
    for (int k = 0; k < LANES; k++) begin
      flipVec[k] = caseFlip(in_data[8*k +: 8], mode);
      convData[8*k +: 8] = in_data[8*k +: 8] ^ {2'b00, flipVec[k], 5'b00000};
      changeCnt = changeCnt + 5'(flipVec[k]);
    end
  end

  // Next-state for the output stage and the saturating counter.
  always_comb begin
    validD = validQ;
    dataD  = dataQ;
    if (accept) begin
      validD = 1'b1;
      dataD  = convData;
    end else if (out_ready) begin
      validD = 1'b0;
    end
    cntBase = cnt_clr ? '0 : SUM_W'(cntQ);
    cntSum  = cntBase + (accept ? SUM_W'(changeCnt) : '0);
    cntD    = (cntSum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(cntSum);
  end

  // State registers; reset drops any held beat and zeroes the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ <= 1'b0;
      dataQ  <= '0;
      cntQ   <= '0;
    end else begin
      validQ <= validD;
      dataQ  <= dataD;
      cntQ   <= cntD;
    end
  end

endmodule
